game_frame_sequencer: RTL and testbench
=======================================

Name: game_frame_sequencer

Overview:
- Sequences the game datapath once per game tick:
  - requests one collision/shift step;
  - waits for completion;
  - scans the 120x100 wall field and the 4x6 dude sprite into the VGA adapter's pixel-write port, one pixel per clock.
- Sits between the control FSM (supplies ingame) and the datapath / vga_adapter.
- Replaces free-running draw counters with a single owner of the plot port.

Parameters:
- TICK_DIV, 833333: clk cycles per game tick (60 Hz at 50 MHz); minimum 12100.
- WALL_W, 120: wall field width in pixels (columns).
- WALL_H, 100: wall field height in pixels (rows).
- X_OFF, 20: screen x of wall column 0.
- Y_OFF, 10: screen y of wall row 0.
- DUDE_W, 4: sprite width.
- DUDE_H, 6: sprite height.

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous reset, active-high
- ingame  in  1  level from control FSM; 1 = game running
- step_req  out  1  one-cycle pulse: datapath performs collision check + wall shift
- step_done  in  1  one-cycle pulse from datapath: step finished, wall memory stable
- wall_rd_addr  out  14  wall bit address = col*WALL_H + row
- wall_rd_data  in  1  wall bit, valid one cycle after wall_rd_addr
- dude_x  in  7  sprite top-left column (field-relative)
- dude_y  in  7  sprite top-left row (field-relative)
- plot  out  1  pixel write strobe to vga_adapter
- plot_x  out  8  screen x
- plot_y  out  7  screen y
- plot_colour  out  3  RGB
- busy  out  1  high from step_req until frame_done
- frame_done  out  1  one-cycle pulse after last sprite pixel plotted
- overrun_cnt  out  8  saturating count of dropped ticks

Behaviour:
- Reset (async, active-high): all outputs 0; state IDLE; tick counter 0; overrun_cnt 0.
- Tick divider:
  - counts 0..TICK_DIV-1 while ingame=1;
  - emits a tick when count = TICK_DIV-1, then wraps to 0;
  - held at 0 while ingame=0.
- States and transitions:
  - IDLE: on tick, go to STEP.
  - STEP: assert step_req for 1 cycle, go to WAIT.
  - WAIT: on step_done, go to WALL; no timeout.
  - WALL:
    - col outer 0..WALL_W-1, row inner 0..WALL_H-1;
    - issue one address per cycle;
    - after the last address, go to DUDE.
  - DUDE:
    - dx 0..DUDE_W-1 outer, dy 0..DUDE_H-1 inner;
    - one pixel per cycle;
    - after the last pixel, go to DONE.
  - DONE: pulse frame_done, go to IDLE.
- Wall pipeline (1-cycle read latency):
  - address issued cycle t → plot=1 at t+1;
  - plot_x = X_OFF+col, plot_y = Y_OFF+row;
  - plot_colour = wall_rd_data ? 3'b111 : 3'b000.
- Sprite pixels:
  - registered, 1-cycle latency, no memory read;
  - plot_x = X_OFF+dude_x+dx, plot_y = Y_OFF+dude_y+dy, colour 3'b100;
  - dude_x/dude_y sampled once on entry to DUDE and held for the whole sprite.
- Plot stream timing:
  - plot is continuous from the first wall pixel through the last sprite pixel: exactly 12024 consecutive plot cycles;
  - frame_done asserts the cycle after the last plot.
- Widths: sums wrap modulo field width (8/7 bits); no clipping.
- busy = 1 in STEP, WAIT, WALL, DUDE, DONE.
- Boundary conditions:
  - Tick while busy: tick dropped; overrun_cnt += 1, saturating at 255; the frame in progress is unaffected.
  - ingame falls mid-frame: next cycle state → IDLE, plot=0, busy=0, no frame_done; a pending step_done is ignored.
  - step_done in any state other than WAIT: ignored.
  - Tick and ingame fall in the same cycle: no step_req.
  - Reset mid-frame: immediate return to reset values; no partial pulses.

Optional Feature:
- Macro: JOSH_CLEAR_ON_EXIT_EN.
- Defined:
  - on ingame 1→0 (including aborting a frame), enter CLEAR;
  - CLEAR plots the whole WALL_W x WALL_H field in colour 3'b000 in the same column-major order, one pixel per cycle;
  - busy=1 during CLEAR; then IDLE with no frame_done;
  - ingame re-rising during CLEAR is ignored until CLEAR ends.
- Undefined: no CLEAR state; behaviour exactly as above.

Decomposition:
- Package josh_pkg:
  - state enum (IDLE, STEP, WAIT, WALL, DUDE, DONE, CLEAR);
  - colour constants COL_WALL=3'b111, COL_BG=3'b000, COL_DUDE=3'b100;
  - default geometry constants.
- Sub-module tick_divider (parameter TICK_DIV; ports clk, reset, en, tick).
- Address/pixel scan counters stay inline in game_frame_sequencer.

Test Plan:
- TICK_DIV=12100, ingame=1 from reset, step_done returned 3 cycles after step_req → step_req at cycle 12100; 12024 consecutive plot cycles; frame_done once; overrun_cnt=0.
- Wall model with bit (col 5,row 7)=1, others 0 → exactly one wall plot with colour 3'b111, at plot_x=25, plot_y=17; remaining wall plots 3'b000.
- dude_x=20, dude_y=94, dude_x changed to 0 mid-DUDE → 24 pixels with colour 3'b100, x 40..43, y 104..109; mid-frame change has no effect.
- Hold step_done off for 3 tick periods → overrun_cnt=3, single step_req; after 300 dropped ticks, overrun_cnt=255.
- Drop ingame at wall pixel 500 → plot=0 and busy=0 the next cycle; no frame_done. With JOSH_CLEAR_ON_EXIT_EN: 12000 plots of colour 3'b000, then busy=0.
- Assert reset asynchronously mid-WALL → plot, busy, step_req, overrun_cnt are 0 before the next clk edge.

Source files
------------

// File: rtl/josh_pkg.sv
// Shared types and constants for the game frame sequencer.
// Holds the FSM state encoding, pixel colours and default playfield geometry.
package josh_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    WAIT  = 3'd2,
    WALL  = 3'd3,
    DUDE  = 3'd4,
    DONE  = 3'd5,
    CLEAR = 3'd6
  } state_t;

  localparam logic [2:0] COL_WALL = 3'b111;
  localparam logic [2:0] COL_BG   = 3'b000;
  localparam logic [2:0] COL_DUDE = 3'b100;

  localparam int TICK_DIV_DEF = 833333;
  localparam int WALL_W_DEF   = 120;
  localparam int WALL_H_DEF   = 100;
  localparam int X_OFF_DEF    = 20;
  localparam int Y_OFF_DEF    = 10;
  localparam int DUDE_W_DEF   = 4;
  localparam int DUDE_H_DEF   = 6;

endpackage

// File: rtl/tick_divider.sv
// Game tick generator: counts 0..TICK_DIV-1 while enabled and pulses on the last count.
// The counter is held at zero while disabled, so a tick never fires with en low.
module tick_divider
  import josh_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(TICK_DIV - 1));
  assign tick   = en && at_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!en || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_frame_sequencer.sv
// Per-tick frame sequencer: one datapath step, then wall field and sprite scanned to the plot port.
// Build option JOSH_CLEAR_ON_EXIT_EN blanks the wall field when ingame drops.
module game_frame_sequencer
  import josh_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int WALL_W   = WALL_W_DEF,
  parameter int WALL_H   = WALL_H_DEF,
  parameter int X_OFF    = X_OFF_DEF,
  parameter int Y_OFF    = Y_OFF_DEF,
  parameter int DUDE_W   = DUDE_W_DEF,
  parameter int DUDE_H   = DUDE_H_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ingame,
  output logic        step_req,
  input  logic        step_done,
  output logic [13:0] wall_rd_addr,
  input  logic        wall_rd_data,
  input  logic [6:0]  dude_x,
  input  logic [6:0]  dude_y,
  output logic        plot,
  output logic [7:0]  plot_x,
  output logic [6:0]  plot_y,
  output logic [2:0]  plot_colour,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  overrun_cnt,
  output state_t      dbg_state
);

  // Step handshake: step_req is a one-cycle request issued from STEP; the datapath answers
  // with a one-cycle step_done, which is honoured only while waiting in WAIT.
  state_t     state, next_state;
  logic       tick;
  logic [6:0] col, row, dude_xs, dude_ys;
  logic [2:0] dx, dy;
  logic       wall_last, dude_last;
  logic       plot_r, wall_pend;
  logic [7:0] px_r;
  logic [6:0] py_r;
  logic [2:0] colour_r;
`ifdef JOSH_CLEAR_ON_EXIT_EN
  logic       ingame_q;
`endif

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (ingame),
    .tick  (tick)
  );

  assign wall_last    = (col == 7'(WALL_W - 1)) && (row == 7'(WALL_H - 1));
  assign dude_last    = (dx == 3'(DUDE_W - 1)) && (dy == 3'(DUDE_H - 1));
  assign wall_rd_addr = 14'(col) * 14'(WALL_H) + 14'(row);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (tick) next_state = STEP;
      STEP:  next_state = WAIT;
      WAIT:  if (step_done) next_state = WALL;
      WALL:  if (wall_last) next_state = DUDE;
      DUDE:  if (dude_last) next_state = DONE;
      DONE:  next_state = IDLE;
`ifdef JOSH_CLEAR_ON_EXIT_EN
      CLEAR: if (wall_last) next_state = IDLE;
`endif
      default: next_state = IDLE;
    endcase
`ifdef JOSH_CLEAR_ON_EXIT_EN
    if (ingame_q && !ingame && state != CLEAR) next_state = CLEAR;
    else if (!ingame && state != CLEAR)        next_state = IDLE;
`else
    if (!ingame) next_state = IDLE;
`endif
  end

  always_comb begin
    step_req  = (state == STEP);
    busy      = (state != IDLE);
    dbg_state = state;
  end

  // Wall data arrives a cycle after its address, so its colour is muxed in at the output.
  assign plot        = plot_r;
  assign plot_x      = px_r;
  assign plot_y      = py_r;
  assign plot_colour = wall_pend ? (wall_rd_data ? COL_WALL : COL_BG) : colour_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col         <= '0;
      row         <= '0;
      dx          <= '0;
      dy          <= '0;
      dude_xs     <= '0;
      dude_ys     <= '0;
      plot_r      <= 1'b0;
      wall_pend   <= 1'b0;
      px_r        <= '0;
      py_r        <= '0;
      colour_r    <= '0;
      frame_done  <= 1'b0;
      overrun_cnt <= '0;
`ifdef JOSH_CLEAR_ON_EXIT_EN
      ingame_q    <= 1'b0;
`endif
    end else begin
`ifdef JOSH_CLEAR_ON_EXIT_EN
      ingame_q <= ingame;
`endif
      frame_done <= (state == DONE) && ingame;
      if (tick && state != IDLE && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;

      // Every state change restarts the scan counters, including an abort into CLEAR.
      if (state != next_state) begin
        col <= '0;
        row <= '0;
        dx  <= '0;
        dy  <= '0;
      end else if (state == WALL || state == CLEAR) begin
        if (row == 7'(WALL_H - 1)) begin
          row <= '0;
          col <= col + 7'd1;
        end else begin
          row <= row + 7'd1;
        end
      end else if (state == DUDE) begin
        if (dy == 3'(DUDE_H - 1)) begin
          dy <= '0;
          dx <= dx + 3'd1;
        end else begin
          dy <= dy + 3'd1;
        end
      end

      if (state != DUDE && next_state == DUDE) begin
        dude_xs <= dude_x;
        dude_ys <= dude_y;
      end

      plot_r    <= 1'b0;
      wall_pend <= 1'b0;
      case (state)
        WALL: if (ingame) begin
          plot_r    <= 1'b1;
          wall_pend <= 1'b1;
          px_r      <= 8'(X_OFF) + {1'b0, col};
          py_r      <= 7'(Y_OFF) + row;
        end
        DUDE: if (ingame) begin
          plot_r   <= 1'b1;
          px_r     <= 8'(X_OFF) + {1'b0, dude_xs} + {5'b0, dx};
          py_r     <= 7'(Y_OFF) + dude_ys + {4'b0, dy};
          colour_r <= COL_DUDE;
        end
`ifdef JOSH_CLEAR_ON_EXIT_EN
        CLEAR: begin
          plot_r   <= 1'b1;
          px_r     <= 8'(X_OFF) + {1'b0, col};
          py_r     <= 7'(Y_OFF) + row;
          colour_r <= COL_BG;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_frame_sequencer.sv
// Self-checking bench for game_frame_sequencer: full frame, wall/sprite pixels, overruns,
// ingame abort, tick/ingame race, overrun saturation and asynchronous reset.
module tb_game_frame_sequencer;
  import josh_pkg::*;

  localparam int TD  = 12100;
  localparam int STD = 16;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, ingame, step_done, wall_rd_data;
  logic [6:0]  dude_x, dude_y;
  logic        step_req, plot, busy, frame_done;
  logic [13:0] wall_rd_addr;
  logic [7:0]  plot_x, overrun_cnt;
  logic [6:0]  plot_y;
  logic [2:0]  plot_colour;
  state_t      dbg_state;

  logic        sat_reset, sat_ingame, sat_step_done, sat_step_req, sat_plot, sat_busy, sat_frame_done;
  logic [13:0] sat_wall_rd_addr;
  logic [7:0]  sat_plot_x, sat_overrun_cnt;
  logic [6:0]  sat_plot_y;
  logic [2:0]  sat_plot_colour;
  state_t      sat_dbg_state;
  logic        sat_wall_rd_data = 1'b0;

  game_frame_sequencer #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .ingame(ingame), .step_req(step_req), .step_done(step_done),
    .wall_rd_addr(wall_rd_addr), .wall_rd_data(wall_rd_data), .dude_x(dude_x), .dude_y(dude_y),
    .plot(plot), .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour), .busy(busy),
    .frame_done(frame_done), .overrun_cnt(overrun_cnt), .dbg_state(dbg_state)
  );

  game_frame_sequencer #(.TICK_DIV(STD)) u_sat (
    .clk(clk), .reset(sat_reset), .ingame(sat_ingame), .step_req(sat_step_req),
    .step_done(sat_step_done), .wall_rd_addr(sat_wall_rd_addr), .wall_rd_data(sat_wall_rd_data),
    .dude_x(dude_x), .dude_y(dude_y), .plot(sat_plot), .plot_x(sat_plot_x), .plot_y(sat_plot_y),
    .plot_colour(sat_plot_colour), .busy(sat_busy), .frame_done(sat_frame_done),
    .overrun_cnt(sat_overrun_cnt), .dbg_state(sat_dbg_state)
  );

  // wall memory: single set bit at col 5, row 7, one-cycle read latency
  always @(posedge clk) wall_rd_data <= (wall_rd_addr == 14'd507);

  int cyc = 0;
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard
  logic [17:0] exp_q[$];
  int pix_total = 0, run_len = 0, last_run = 0, white_cnt = 0;
  int step_cnt = 0, done_cnt = 0, done_cyc = -1, last_plot_cyc = -1, sat_step_cnt = 0;

  always @(negedge clk) begin
    logic [17:0] got, exp_pix;
    if (!sat_reset && sat_step_req) sat_step_cnt++;
    if (reset) begin
      run_len = 0;
    end else begin
      if (step_req) step_cnt++;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (plot) begin
        pix_total++;
        run_len++;
        last_plot_cyc = cyc;
        if (plot_colour == 3'b111) white_cnt++;
        got = {plot_x, plot_y, plot_colour};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          if (n_err <= 20) $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d, expected no plot", plot_x, plot_y, plot_colour);
        end else begin
          exp_pix = exp_q.pop_front();
          if (got !== exp_pix) begin
            n_err++;
            if (n_err <= 20) $display("FAIL pixel: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
              got[17:10], got[9:3], got[2:0], exp_pix[17:10], exp_pix[9:3], exp_pix[2:0]);
          end
        end
      end else if (run_len > 0) begin
        last_run = run_len;
        run_len  = 0;
      end
    end
  end

  task automatic push_frame(input int n_wall, input bit sprite, input int dxs, input int dys);
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    for (int i = 0; i < n_wall; i++) begin
      x = 8'(20 + i / 100);
      y = 7'(10 + i % 100);
      c = (i == 507) ? 3'b111 : 3'b000;
      exp_q.push_back({x, y, c});
    end
    if (sprite) begin
      for (int ddx = 0; ddx < 4; ddx++) begin
        for (int ddy = 0; ddy < 6; ddy++) begin
          x = 8'(20 + dxs + ddx);
          y = 7'(10 + dys + ddy);
          exp_q.push_back({x, y, 3'b100});
        end
      end
    end
  endtask

  task automatic push_clear();
    for (int i = 0; i < 12000; i++) exp_q.push_back({8'(20 + i / 100), 7'(10 + i % 100), 3'b000});
  endtask

  task automatic test_reset();
    reset = 1'b1; sat_reset = 1'b1; ingame = 1'b1; step_done = 1'b0;
    sat_ingame = 1'b0; sat_step_done = 1'b0; dude_x = 7'd20; dude_y = 7'd94;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({plot, busy, step_req, frame_done} !== 4'b0000) begin
      n_err++; $display("FAIL reset_strobes: got %b expected 0000", {plot, busy, step_req, frame_done});
    end
    n_cmp++;
    if (overrun_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_overrun: got %0d expected 0", overrun_cnt);
    end
    n_cmp++;
    if ({plot_x, plot_y, plot_colour} !== 18'd0) begin
      n_err++; $display("FAIL reset_pixel: got %h expected 0", {plot_x, plot_y, plot_colour});
    end
    n_cmp++;
    if (dbg_state !== IDLE) begin
      n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
    reset = 1'b0;
  endtask

  task automatic test_frame();
    bit ok;
    int base, d0, w0, k;
    ok = 1'b0;
    for (int i = 0; i < TD + 20; i++) begin
      @(negedge clk);
      if (step_req) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok || cyc != TD) begin
      n_err++; $display("FAIL step_req_cycle: got %0d (seen=%0d) expected %0d", cyc, ok, TD);
    end
    @(negedge clk);
    n_cmp++;
    if (step_req !== 1'b0) begin
      n_err++; $display("FAIL step_req_width: got %b expected 0", step_req);
    end
    repeat (2) @(negedge clk);
    base = pix_total; d0 = done_cnt; w0 = white_cnt;
    push_frame(12000, 1'b1, 20, 94);
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    k = 0;
    for (int i = 0; i < 12100 && k < 12005; i++) begin
      @(negedge clk);
      if (plot) k++;
    end
    dude_x = 7'd0;
    for (int i = 0; i < 100 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 != 1) begin
      n_err++; $display("FAIL frame_done_count: got %0d expected 1", done_cnt - d0);
    end
    n_cmp++;
    if (pix_total - base != 12024 || last_run != 12024) begin
      n_err++; $display("FAIL plot_run: got total %0d run %0d expected 12024", pix_total - base, last_run);
    end
    n_cmp++;
    if (done_cyc != last_plot_cyc + 1) begin
      n_err++; $display("FAIL frame_done_timing: got cycle %0d expected %0d", done_cyc, last_plot_cyc + 1);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL frame_leftover: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (white_cnt - w0 != 1) begin
      n_err++; $display("FAIL wall_white_count: got %0d expected 1", white_cnt - w0);
    end
    n_cmp++;
    if (overrun_cnt !== 8'd0 || busy !== 1'b0) begin
      n_err++; $display("FAIL frame_end_status: got overrun %0d busy %b expected 0 0", overrun_cnt, busy);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    int s0;
    s0 = step_cnt; ok = 1'b0;
    for (int i = 0; i < TD + 20; i++) begin
      @(negedge clk);
      if (step_req) begin ok = 1'b1; break; end
    end
    n_cmp++;
    if (!ok || cyc != 2 * TD) begin
      n_err++; $display("FAIL second_step_cycle: got %0d (seen=%0d) expected %0d", cyc, ok, 2 * TD);
    end
    repeat (3 * TD + 5) @(negedge clk);
    n_cmp++;
    if (overrun_cnt !== 8'd3) begin
      n_err++; $display("FAIL overrun_three: got %0d expected 3", overrun_cnt);
    end
    n_cmp++;
    if (step_cnt - s0 != 1) begin
      n_err++; $display("FAIL overrun_step_reqs: got %0d expected 1", step_cnt - s0);
    end
    n_cmp++;
    if (dbg_state !== WAIT || busy !== 1'b1) begin
      n_err++; $display("FAIL overrun_waiting: got state %0d busy %b expected %0d 1", dbg_state, busy, WAIT);
    end
  endtask

  task automatic test_abort();
    int base, d0, s0, k;
    base = pix_total; d0 = done_cnt;
    push_frame(500, 1'b0, 0, 0);
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    k = 0;
    for (int i = 0; i < 1000 && k < 500; i++) begin
      @(negedge clk);
      if (plot) k++;
    end
    ingame = 1'b0;
`ifdef JOSH_CLEAR_ON_EXIT_EN
    push_clear();
`endif
    @(negedge clk);
    n_cmp++;
    if (plot !== 1'b0) begin
      n_err++; $display("FAIL abort_plot: got %b expected 0", plot);
    end
`ifdef JOSH_CLEAR_ON_EXIT_EN
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL abort_clear_busy: got %b expected 1", busy);
    end
    for (int i = 0; i < 12100 && busy; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (pix_total - base != 12500 || busy !== 1'b0) begin
      n_err++; $display("FAIL clear_plots: got %0d busy %b expected 12500 0", pix_total - base, busy);
    end
`else
    n_cmp++;
    if (busy !== 1'b0 || dbg_state !== IDLE) begin
      n_err++; $display("FAIL abort_busy: got busy %b state %0d expected 0 %0d", busy, dbg_state, IDLE);
    end
    s0 = step_cnt;
    step_done = 1'b1;
    @(negedge clk);
    step_done = 1'b0;
    repeat (50) @(negedge clk);
    n_cmp++;
    if (pix_total - base != 500 || busy !== 1'b0 || step_cnt != s0) begin
      n_err++; $display("FAIL abort_quiet: got plots %0d busy %b steps %0d expected 500 0 0",
        pix_total - base, busy, step_cnt - s0);
    end
`endif
    n_cmp++;
    if (done_cnt != d0) begin
      n_err++; $display("FAIL abort_frame_done: got %0d expected 0", done_cnt - d0);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL abort_leftover: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_tick_fall();
    int s0;
    @(negedge clk);
    sat_reset = 1'b0;
    @(negedge clk);
    sat_ingame = 1'b1;
    repeat (STD - 1) @(negedge clk);
    sat_ingame = 1'b0;
    s0 = sat_step_cnt;
    repeat (40) @(negedge clk);
    n_cmp++;
    if (sat_step_cnt != s0) begin
      n_err++; $display("FAIL tick_fall_step: got %0d step_req expected 0", sat_step_cnt - s0);
    end
`ifdef JOSH_CLEAR_ON_EXIT_EN
    for (int i = 0; i < 12100 && sat_busy; i++) @(negedge clk);
`else
    n_cmp++;
    if (sat_dbg_state !== IDLE) begin
      n_err++; $display("FAIL tick_fall_state: got %0d expected %0d", sat_dbg_state, IDLE);
    end
`endif
  endtask

  task automatic test_saturate();
    int s0;
    s0 = sat_step_cnt;
    sat_ingame = 1'b1;
    repeat (330 * STD) @(negedge clk);
    n_cmp++;
    if (sat_overrun_cnt !== 8'd255) begin
      n_err++; $display("FAIL overrun_saturate: got %0d expected 255", sat_overrun_cnt);
    end
    n_cmp++;
    if (sat_step_cnt - s0 != 1 || sat_dbg_state !== WAIT) begin
      n_err++; $display("FAIL saturate_single_step: got %0d state %0d expected 1 %0d",
        sat_step_cnt - s0, sat_dbg_state, WAIT);
    end
  endtask

  task automatic test_async_reset();
    sat_step_done = 1'b1;
    @(negedge clk);
    sat_step_done = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (sat_plot !== 1'b1 || sat_busy !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_wall: got plot %b busy %b expected 1 1", sat_plot, sat_busy);
    end
    #2 sat_reset = 1'b1;
    #1;
    n_cmp++;
    if ({sat_plot, sat_busy, sat_step_req, sat_frame_done} !== 4'b0000) begin
      n_err++; $display("FAIL async_reset_strobes: got %b expected 0000",
        {sat_plot, sat_busy, sat_step_req, sat_frame_done});
    end
    n_cmp++;
    if (sat_overrun_cnt !== 8'd0) begin
      n_err++; $display("FAIL async_reset_overrun: got %0d expected 0", sat_overrun_cnt);
    end
    @(negedge clk);
    sat_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_overrun();
    test_abort();
    test_tick_fall();
    test_saturate();
    test_async_reset();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
